// File: rtl/led_pwm_ctrl_pkg.sv
// Shared defaults, commit-state encoding and the board LED-to-channel map
// for the LED PWM brightness controller.
package led_pwm_pkg;

  localparam int unsigned DEF_NUM_CH   = 12;
  localparam int unsigned DEF_DUTY_W   = 8;
  localparam int unsigned DEF_ADDR_W   = 4;
  localparam int unsigned DEF_PRESCALE = 16;
  localparam int unsigned NUM_LEDS     = 4;

  typedef enum logic {
    ST_IDLE,
    ST_PENDING
  } commit_state_e;

  // Channel index of each colour of RGB LED 'led' (0..NUM_LEDS-1).
  function automatic int unsigned ch_r(input int unsigned led);
    return 2 * led;
  endfunction

  function automatic int unsigned ch_g(input int unsigned led);
    return 2 * led + 1;
  endfunction

  function automatic int unsigned ch_b(input int unsigned led);
    return 2 * NUM_LEDS + led;
  endfunction

endpackage

// File: rtl/led_pwm_ctrl_if.sv
// Duty write port and commit handshake between the SoC bus side (master)
// and the PWM controller (slave).
interface led_pwm_ctrl_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DUTY_W = 8
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DUTY_W-1:0] wr_data;
  logic              wr_err;
  logic              commit;
  logic              pending;

  modport master (
    output wr_valid, wr_addr, wr_data, commit,
    input  wr_ready, wr_err, pending
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, commit,
    output wr_ready, wr_err, pending
  );
endinterface

// File: rtl/led_pwm_ctrl_timebase.sv
// PWM timebase: prescaler and step counter; flags each step (tick) and the
// last step of a period (wrap).
module pwm_timebase #(
  parameter int unsigned DUTY_W   = 8,
  parameter int unsigned PRESCALE = 16
) (
  input  logic              clk,
  input  logic              resetn,
  output logic [DUTY_W-1:0] cnt_o,
  output logic              tick_o,
  output logic              wrap_o
);

  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [DUTY_W-1:0] cnt_q, cnt_d;
  logic              tick;

  assign tick = (pre_q == PRE_W'(PRESCALE - 1));

  always_comb begin
    pre_d = tick ? '0 : pre_q + 1'b1;
    cnt_d = tick ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign tick_o = tick;
  assign wrap_o = tick && (cnt_q == '1);

endmodule

// File: rtl/led_pwm_ctrl.sv
// Per-channel PWM LED driver: shadow duty registers loaded over a valid/ready
// port, copied to the active set only at a period boundary after a commit.
module led_pwm_ctrl
  import led_pwm_pkg::*;
#(
  parameter int unsigned NUM_CH   = DEF_NUM_CH,
  parameter int unsigned DUTY_W   = DEF_DUTY_W,
  parameter int unsigned PRESCALE = DEF_PRESCALE,
  parameter int unsigned ADDR_W   = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              resetn,
  led_pwm_ctrl_if.slave     bus,
  output logic              period_start,
  output logic [NUM_CH-1:0] led_o
);

  localparam logic [ADDR_W:0] NUM_CH_L = (ADDR_W + 1)'(NUM_CH);

  logic [DUTY_W-1:0] cnt;
  logic              tick;
  logic              wrap;

  commit_state_e     state_q, state_d;
  logic [DUTY_W-1:0] shadow_q [NUM_CH];
  logic [DUTY_W-1:0] shadow_d [NUM_CH];
  logic [DUTY_W-1:0] active_q [NUM_CH];
  logic [DUTY_W-1:0] active_d [NUM_CH];
  logic              wr_err_q, wr_err_d;
  logic              period_start_q;
  logic              step_q;
  logic [NUM_CH-1:0] led_q, led_d;
  logic              xfer;
  logic              addr_ok;

  pwm_timebase #(
    .DUTY_W   (DUTY_W),
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .clk    (clk),
    .resetn (resetn),
    .cnt_o  (cnt),
    .tick_o (tick),
    .wrap_o (wrap)
  );

  assign bus.wr_ready = (state_q == ST_IDLE);
  assign bus.pending  = (state_q == ST_PENDING);
  assign bus.wr_err   = wr_err_q;

  assign xfer    = bus.wr_valid && bus.wr_ready;
  assign addr_ok = ({1'b0, bus.wr_addr} < NUM_CH_L);

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    active_d = active_q;
    wr_err_d = xfer && !addr_ok;
    led_d    = led_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.commit) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        if (wrap) begin
          state_d  = ST_IDLE;
          active_d = shadow_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Writes are only accepted while idle, so they can never race the snapshot.
    if (xfer && addr_ok) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (bus.wr_addr == ADDR_W'(i)) shadow_d[i] = bus.wr_data;
      end
    end

    // cnt and active only ever change on a step, so refresh the compare just after one.
    if (step_q) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        led_d[i] = (cnt < active_q[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= ST_IDLE;
      shadow_q       <= '{default: '0};
      active_q       <= '{default: '0};
      wr_err_q       <= 1'b0;
      period_start_q <= 1'b0;
      step_q         <= 1'b0;
      led_q          <= '0;
    end else begin
      state_q        <= state_d;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      wr_err_q       <= wr_err_d;
      period_start_q <= wrap;
      step_q         <= tick;
      led_q          <= led_d;
    end
  end

  assign period_start = period_start_q;
  assign led_o        = led_q;

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Directed bench for led_pwm_ctrl with PRESCALE=2 (512-cycle PWM period).
module tb_led_pwm_ctrl;
  import led_pwm_pkg::*;

  localparam int unsigned NCH    = 12;
  localparam int unsigned PS     = 2;
  localparam int          PERIOD = 256 * PS;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             period_start;
  logic [NCH-1:0]   led_o;

  int checks   = 0;
  int failures = 0;
  int hi_cnt [NCH];

  led_pwm_ctrl_if #(.ADDR_W(4), .DUTY_W(8)) bus_if ();

  led_pwm_ctrl #(
    .NUM_CH   (NCH),
    .DUTY_W   (8),
    .PRESCALE (PS),
    .ADDR_W   (4)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .bus          (bus_if),
    .period_start (period_start),
    .led_o        (led_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ps(input string name, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!period_start && n < PERIOD + 16);
    checks++;
    if (!period_start) begin
      failures++;
      $display("FAIL %s: no period_start within %0d cycles", name, n);
    end
  endtask

  task automatic count_period();
    for (int c = 0; c < NCH; c++) hi_cnt[c] = 0;
    repeat (PERIOD) begin
      for (int c = 0; c < NCH; c++) if (led_o[c]) hi_cnt[c]++;
      step();
    end
  endtask

  task automatic write_ch(input int addr, input int data, input string name);
    int n;
    n = 0;
    bus_if.wr_valid = 1'b1;
    bus_if.wr_addr  = 4'(addr);
    bus_if.wr_data  = 8'(data);
    while (!bus_if.wr_ready && n < 2000) begin
      step();
      n++;
    end
    if (!bus_if.wr_ready) begin
      checks++;
      failures++;
      $display("FAIL %s: wr_ready never returned", name);
    end
    step();
    bus_if.wr_valid = 1'b0;
  endtask

  task automatic pulse_commit();
    bus_if.commit = 1'b1;
    step();
    bus_if.commit = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    resetn          = 1'b0;
    bus_if.wr_valid = 1'b1;
    bus_if.wr_addr  = 4'd0;
    bus_if.wr_data  = 8'hFF;
    bus_if.commit   = 1'b1;
    repeat (3) step();
    checks++;
    if (led_o !== '0) begin failures++; $display("FAIL reset_led: got %h want 000", led_o); end
    checks++;
    if (bus_if.pending !== 1'b0) begin failures++; $display("FAIL reset_pending: got %b want 0", bus_if.pending); end
    checks++;
    if (bus_if.wr_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", bus_if.wr_ready); end
    checks++;
    if (bus_if.wr_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", bus_if.wr_err); end
    checks++;
    if (period_start !== 1'b0) begin failures++; $display("FAIL reset_ps: got %b want 0", period_start); end
    resetn          = 1'b1;
    bus_if.wr_valid = 1'b0;
    bus_if.commit   = 1'b0;
    wait_ps("reset_first_ps", n);
    checks++;
    if (n != PERIOD) begin failures++; $display("FAIL reset_first_ps_delay: got %0d want %0d", n, PERIOD); end
  endtask

  task automatic test_duty();
    int n;
    write_ch(0, 64, "duty_w0");
    write_ch(1, 0, "duty_w1");
    write_ch(2, 255, "duty_w2");
    pulse_commit();
    checks++;
    if (bus_if.pending !== 1'b1) begin failures++; $display("FAIL duty_pending: got %b want 1", bus_if.pending); end
    wait_ps("duty_apply", n);
    checks++;
    if (bus_if.pending !== 1'b0) begin failures++; $display("FAIL duty_pending_clr: got %b want 0", bus_if.pending); end
    step();
    count_period();
    checks++;
    if (hi_cnt[0] != 128) begin failures++; $display("FAIL duty_ch0: got %0d want 128", hi_cnt[0]); end
    checks++;
    if (hi_cnt[1] != 0) begin failures++; $display("FAIL duty_ch1: got %0d want 0", hi_cnt[1]); end
    checks++;
    if (hi_cnt[2] != 510) begin failures++; $display("FAIL duty_ch2: got %0d want 510", hi_cnt[2]); end
  endtask

  task automatic test_stall();
    int n;
    wait_ps("stall_align", n);
    repeat (10) step();
    pulse_commit();
    bus_if.wr_valid = 1'b1;
    bus_if.wr_addr  = 4'd3;
    bus_if.wr_data  = 8'd10;
    checks++;
    if (bus_if.wr_ready !== 1'b0) begin failures++; $display("FAIL stall_ready: got %b want 0", bus_if.wr_ready); end
    n = 0;
    while (!bus_if.wr_ready && n < PERIOD + 16) begin
      step();
      n++;
    end
    checks++;
    if (n != PERIOD - 11) begin failures++; $display("FAIL stall_len: got %0d want %0d", n, PERIOD - 11); end
    checks++;
    if (period_start !== 1'b1 || bus_if.pending !== 1'b0) begin
      failures++;
      $display("FAIL stall_release: ps=%b pending=%b want ps=1 pending=0", period_start, bus_if.pending);
    end
    step();
    bus_if.wr_valid = 1'b0;
    count_period();
    checks++;
    if (hi_cnt[3] != 0) begin failures++; $display("FAIL stall_active3: got %0d want 0", hi_cnt[3]); end
  endtask

  task automatic test_commit_on_wrap();
    int n;
    int bad;
    wait_ps("cow_align", n);
    write_ch(4, 100, "cow_w4");
    repeat (PERIOD - 2) step();
    pulse_commit();
    checks++;
    if (period_start !== 1'b1 || bus_if.pending !== 1'b1) begin
      failures++;
      $display("FAIL cow_set: ps=%b pending=%b want ps=1 pending=1", period_start, bus_if.pending);
    end
    bad = 0;
    repeat (PERIOD - 1) begin
      step();
      if (bus_if.pending !== 1'b1 || led_o[4] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL cow_hold: got %0d bad cycles want 0", bad); end
    step();
    checks++;
    if (period_start !== 1'b1 || bus_if.pending !== 1'b0) begin
      failures++;
      $display("FAIL cow_apply: ps=%b pending=%b want ps=1 pending=0", period_start, bus_if.pending);
    end
    step();
    count_period();
    checks++;
    if (hi_cnt[4] != 200) begin failures++; $display("FAIL cow_ch4: got %0d want 200", hi_cnt[4]); end
    checks++;
    if (hi_cnt[3] != 20) begin failures++; $display("FAIL cow_ch3: got %0d want 20", hi_cnt[3]); end
  endtask

  task automatic test_bad_addr();
    int n;
    int exp_hi [NCH];
    exp_hi = '{128, 0, 510, 20, 200, 0, 0, 0, 0, 0, 0, 0};
    bus_if.wr_valid = 1'b1;
    bus_if.wr_addr  = 4'd13;
    bus_if.wr_data  = 8'hAA;
    checks++;
    if (bus_if.wr_ready !== 1'b1) begin failures++; $display("FAIL bad_ready: got %b want 1", bus_if.wr_ready); end
    step();
    bus_if.wr_valid = 1'b0;
    checks++;
    if (bus_if.wr_err !== 1'b1) begin failures++; $display("FAIL bad_err_pulse: got %b want 1", bus_if.wr_err); end
    step();
    checks++;
    if (bus_if.wr_err !== 1'b0) begin failures++; $display("FAIL bad_err_clear: got %b want 0", bus_if.wr_err); end
    pulse_commit();
    wait_ps("bad_apply", n);
    step();
    count_period();
    for (int c = 0; c < NCH; c++) begin
      checks++;
      if (hi_cnt[c] != exp_hi[c]) begin
        failures++;
        $display("FAIL bad_ch%0d: got %0d want %0d", c, hi_cnt[c], exp_hi[c]);
      end
    end
    checks++;
    if (hi_cnt[ch_b(1)] != 0) begin failures++; $display("FAIL bad_led1_blue: got %0d want 0", hi_cnt[ch_b(1)]); end
  endtask

  task automatic test_mid_reset();
    int n;
    int total;
    wait_ps("mid_align", n);
    write_ch(5, 50, "mid_w5");
    pulse_commit();
    repeat (198) step();
    checks++;
    if (bus_if.pending !== 1'b1 || led_o[2] !== 1'b1) begin
      failures++;
      $display("FAIL mid_pre: pending=%b led2=%b want 1 1", bus_if.pending, led_o[2]);
    end
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    checks++;
    if (led_o !== '0 || bus_if.pending !== 1'b0 || period_start !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_out: led=%h pending=%b ps=%b want 000 0 0", led_o, bus_if.pending, period_start);
    end
    pulse_commit();
    wait_ps("mid_after", n);
    checks++;
    if (n != PERIOD - 1) begin failures++; $display("FAIL mid_first_ps: got %0d want %0d", n, PERIOD - 1); end
    step();
    count_period();
    total = 0;
    for (int c = 0; c < NCH; c++) total += hi_cnt[c];
    checks++;
    if (total != 0) begin failures++; $display("FAIL mid_dark: got %0d high samples want 0", total); end
  endtask

  initial begin
    bus_if.wr_valid = 1'b0;
    bus_if.wr_addr  = '0;
    bus_if.wr_data  = '0;
    bus_if.commit   = 1'b0;
    test_reset();
    test_duty();
    test_stall();
    test_commit_on_wrap();
    test_bad_addr();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
